// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames. It oversamples the rx line on a shared baud tick,
// delivers each good word with a one-cycle valid strobe, and flags bad stop bits.
module uart_rx #(
  parameter int unsigned Oversample = 16,
  parameter int unsigned DataBits   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_tick_i,
  input  logic                rx_i,
  output logic [DataBits-1:0] data_o,
  output logic                valid_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam int unsigned CntW = $clog2(Oversample);
  localparam logic [CntW-1:0] CntHalf = CntW'(Oversample / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Oversample - 1);
  localparam logic [2:0]      LastBit = 3'(DataBits - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; everything holds on clocks without a sample tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (sample_tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            // Still low at mid start bit: a real frame, otherwise a glitch.
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            shift_d = {rx_s_q, shift_q[DataBits-1:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == LastBit) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StWaitHigh;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitHigh: begin
          // A held-low line (break) must not look like a new start bit.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboard of expected words/frame errors, checked by a monitor.
module tb_uart_rx;

  localparam int BitClk = 64;  // 16 ticks per bit, one tick every 4 clk

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .Oversample(16),
    .DataBits  (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sample_tick_i(tick),
    .rx_i         (rx),
    .data_o       (data),
    .valid_o      (valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide pulse every fourth clock.
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      tick = (k % 4 == 0);
      k++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a frame is the start bit, data LSB first, then the stop bit.
  // A good stop delivers the byte; a bad stop reports an error and leaves data as it was.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = stop ? b : last_good;
    if (stop) last_good = b;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BitClk);
    end
    rx = stop;
    wait_clk(BitClk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every output strobe consumes one expected event.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      exp_t e;
      check("strobes_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
        check("strobe_data", {24'd0, data}, {24'd0, e.data});
        check("busy_at_strobe", {31'd0, busy}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    int         gap;
    int         seen_busy;

    // Reset held with rx toggling.
    for (int i = 0; i < 20; i++) begin
      rx = ~rx;
      wait_clk(3);
    end
    rx = 1'b1;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_clk(200);
    check("idle_data", {24'd0, data}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single byte with busy timing.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_clk(2);
        check("busy_before_sync", {31'd0, busy}, 32'd0);
        wait_clk(8);
        check("busy_after_start", {31'd0, busy}, 32'd1);
      end
    join
    drain("drain_single");
    check("single_data", {24'd0, data}, 32'hA5);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("drain_b2b");
    check("b2b_data", {24'd0, data}, 32'h3C);

    // Glitch: 12 clk low, then high.
    wait_clk(100);
    rx = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    rx = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    check("glitch_seen_busy", seen_busy, 1);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    wait_clk(30);
    send_frame(8'h5A, 1'b1);
    drain("drain_glitch");

    // Framing error followed by a long break.
    wait_clk(50);
    send_frame(8'h81, 1'b0);
    wait_clk(500);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data_kept", {24'd0, data}, 32'h5A);
    wait_clk(500);
    check("break_busy_late", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_clk(20);
    check("break_recovered", {31'd0, busy}, 32'd0);
    drain("drain_break");
    wait_clk(60);
    send_frame(8'h42, 1'b1);
    drain("drain_after_break");
    check("after_break_data", {24'd0, data}, 32'h42);

    // Reset asserted during data bit 4 of 0x99.
    wait_clk(40);
    b = 8'h99;
    rx = 1'b0;
    wait_clk(BitClk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clk(BitClk);
    end
    rx = b[4];
    wait_clk(BitClk / 2);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_data", {24'd0, data}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_ferr", {31'd0, frame_err}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(100);
    send_frame(8'h66, 1'b1);
    drain("drain_after_abort");
    check("after_abort_data", {24'd0, data}, 32'h66);

    // Randomized frames, occasional bad stop bits, random gaps.
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      if (!stop) begin
        wait_clk(10);
        rx = 1'b1;
        gap = $urandom_range(70, 150);
      end else begin
        gap = $urandom_range(0, 100);
      end
      wait_clk(gap);
    end
    drain("drain_random");
    check("random_last_data", {24'd0, data}, {24'd0, last_good});
    wait_clk(100);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
